clk_div_prog: RTL and testbench



---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_prog_if.sv | 22 ++
 rtl/clk_div_cfg_shadow.sv | 51 +++++
 rtl/clk_div_prog.sv | 110 +++++++++++
 tb/tb_clk_div_prog.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared types, defaults and config validation for the programmable clock divider.
package clk_div_pkg;

   localparam int unsigned CNT_W_DEF = 16;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Valid iff period >= 2 and 1 <= low phase <= period-1.
   function automatic logic cfg_valid(input logic [31:0] div, input logic [31:0] low);
      return (div >= 32'd2) && (low >= 32'd1) && (low < div);
   endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Configuration bus of the clock divider: load request, requested P/L, ack/err pulses.
import clk_div_pkg::*;

interface clk_div_prog_if #(
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic             cfg_wr;
   logic [CNT_W-1:0] div_val;
   logic [CNT_W-1:0] low_val;
   logic             cfg_ack;
   logic             cfg_err;

   modport master (
      output cfg_wr, div_val, low_val,
      input  cfg_ack, cfg_err
   );

   modport slave (
      input  cfg_wr, div_val, low_val,
      output cfg_ack, cfg_err
   );
endinterface

// File: rtl/clk_div_cfg_shadow.sv
// Validates configuration writes and holds the pending shadow period/low-phase values.
import clk_div_pkg::*;

module clk_div_cfg_shadow #(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_cfg_wr,
   input  logic [CNT_W-1:0] i_div_val,
   input  logic [CNT_W-1:0] i_low_val,
   input  logic             i_apply,
   output logic             o_pending,
   output logic [CNT_W-1:0] o_sh_div,
   output logic [CNT_W-1:0] o_sh_low,
   output logic             o_cfg_err
);

   logic             w_valid;
   logic             r_pending;
   logic [CNT_W-1:0] r_sh_div;
   logic [CNT_W-1:0] r_sh_low;
   logic             r_cfg_err;

   assign w_valid = cfg_valid(32'(i_div_val), 32'(i_low_val));

   // A write landing on the apply edge refills the shadow, so pending stays set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pending <= 1'b0;
         r_sh_div  <= '0;
         r_sh_low  <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= i_cfg_wr & ~w_valid;
         if (i_cfg_wr && w_valid) begin
            r_sh_div  <= i_div_val;
            r_sh_low  <= i_low_val;
            r_pending <= 1'b1;
         end else if (i_apply) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign o_pending = r_pending;
   assign o_sh_div  = r_sh_div;
   assign o_sh_low  = r_sh_low;
   assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable clock divider: run/stop FSM, period counter, registered local clock and edge strobes.
import clk_div_pkg::*;

module clk_div_prog #(
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned DEF_DIV = 128,
   parameter int unsigned DEF_LOW = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flag,
   clk_div_prog_if.slave  cfg,
   output logic           clk_local,
   output logic           rise_stb,
   output logic           fall_stb,
   output logic           running
);

   state_e           r_state;
   state_e           w_state_n;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_n;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] r_pm1;
   logic [CNT_W-1:0] r_low;
   logic             r_clk;
   logic             w_clk_n;
   logic             r_rise;
   logic             r_fall;
   logic             r_ack;

   logic             w_pending;
   logic [CNT_W-1:0] w_sh_div;
   logic [CNT_W-1:0] w_sh_low;
   logic             w_cfg_err;
   logic             w_wrap;
   logic             w_apply;

   clk_div_cfg_shadow #(
      .CNT_W (CNT_W)
   ) u_shadow (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_cfg_wr  (cfg.cfg_wr),
      .i_div_val (cfg.div_val),
      .i_low_val (cfg.low_val),
      .i_apply   (w_apply),
      .o_pending (w_pending),
      .o_sh_div  (w_sh_div),
      .o_sh_low  (w_sh_low),
      .o_cfg_err (w_cfg_err)
   );

   assign w_wrap    = (r_state == RUN) && (r_cnt == r_pm1);
   assign w_cnt_inc = r_cnt + 1'b1;
   // Apply only at a period boundary: any IDLE edge, or a RUN wrap that keeps running.
   assign w_apply   = w_pending && ((r_state == IDLE) || (flag && w_wrap));

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = '0;
      w_clk_n   = 1'b0;
      case (r_state)
         IDLE: begin
            if (flag) w_state_n = RUN;
         end
         RUN: begin
            if (!flag) begin
               w_state_n = IDLE;
            end else if (!w_wrap) begin
               w_cnt_n = w_cnt_inc;
               w_clk_n = (w_cnt_inc >= r_low);
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_pm1   <= CNT_W'(DEF_DIV - 1);
         r_low   <= CNT_W'(DEF_LOW);
         r_clk   <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_clk   <= w_clk_n;
         r_rise  <= w_clk_n & ~r_clk;
         r_fall  <= ~w_clk_n & r_clk;
         r_ack   <= w_apply;
         if (w_apply) begin
            r_pm1 <= w_sh_div - 1'b1;
            r_low <= w_sh_low;
         end
      end
   end

   assign clk_local   = r_clk;
   assign rise_stb    = r_rise;
   assign fall_stb    = r_fall;
   assign running     = (r_state == RUN);
   assign cfg.cfg_ack = r_ack;
   assign cfg.cfg_err = w_cfg_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: a period/phase reference model queues expected outputs per cycle.
module tb_clk_div_prog;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic flag;
   logic clk_local;
   logic rise_stb;
   logic fall_stb;
   logic running;

   clk_div_prog_if #(.CNT_W(16)) cfg_if ();

   clk_div_prog #(
      .CNT_W   (16),
      .DEF_DIV (128),
      .DEF_LOW (64)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flag      (flag),
      .cfg       (cfg_if),
      .clk_local (clk_local),
      .rise_stb  (rise_stb),
      .fall_stb  (fall_stb),
      .running   (running)
   );

   logic [5:0] exp_q[$];
   int         total = 0;
   int         bad   = 0;

   bit want_rst_n = 1'b0;
   bit want_flag  = 1'b0;

   // Reference model: position within the period, active and shadow configuration.
   bit m_run  = 1'b0;
   int m_pos  = 0;
   int m_P    = 128;
   int m_L    = 64;
   int m_sP   = 0;
   int m_sL   = 0;
   bit m_pend = 1'b0;
   bit m_prev = 1'b0;

   task automatic tick(input bit wr, input int d, input int l);
      bit         valid;
      bit         apply;
      bit         clk_n;
      logic [5:0] e;
      @(negedge clk);
      rst_n          = want_rst_n;
      flag           = want_flag;
      cfg_if.cfg_wr  = wr;
      cfg_if.div_val = 16'(d);
      cfg_if.low_val = 16'(l);
      if (!want_rst_n) begin
         m_run  = 1'b0;
         m_pos  = 0;
         m_P    = 128;
         m_L    = 64;
         m_pend = 1'b0;
         m_prev = 1'b0;
         e      = '0;
      end else begin
         valid = (d >= 2) && (l >= 1) && (l < d);
         apply = m_pend && (!m_run || (want_flag && m_pos == m_P - 1));
         if (m_run) begin
            if (want_flag) m_pos = (m_pos + 1) % m_P;
            else begin
               m_run = 1'b0;
               m_pos = 0;
            end
         end else if (want_flag) begin
            m_run = 1'b1;
            m_pos = 0;
         end
         if (apply) begin
            m_P = m_sP;
            m_L = m_sL;
         end
         if (wr && valid) begin
            m_sP   = d;
            m_sL   = l;
            m_pend = 1'b1;
         end else if (apply) begin
            m_pend = 1'b0;
         end
         clk_n  = m_run && (m_pos >= m_L);
         e      = {apply, wr && !valid, clk_n, clk_n && !m_prev, !clk_n && m_prev, m_run};
         m_prev = clk_n;
      end
      exp_q.push_back(e);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 0, 0);
   endtask

   task automatic wait_pos(input int target, input int budget);
      int b;
      b = budget;
      while (!(m_run && m_pos == target) && b > 0) begin
         tick(1'b0, 0, 0);
         b--;
      end
      if (b == 0 && !(m_run && m_pos == target)) begin
         total++;
         bad++;
         $display("FAIL wait_pos target=%0d got_pos=%0d required_pos=%0d", target, m_pos, target);
      end
   endtask

   // Monitor: one expected output vector per clock, compared just after the edge.
   initial begin
      logic [5:0] e;
      logic [5:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {cfg_if.cfg_ack, cfg_if.cfg_err, clk_local, rise_stb, fall_stb, running};
            total++;
            if (got !== e) begin
               bad++;
               $display("FAIL outputs t=%0t ack,err,clk,rise,fall,run got=%b required=%b", $time, got, e);
            end
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      flag           = 1'b0;
      cfg_if.cfg_wr  = 1'b0;
      cfg_if.div_val = '0;
      cfg_if.low_val = '0;

      want_rst_n = 1'b0;
      idle_n(2);
      want_rst_n = 1'b1;
      idle_n(3);

      // Defaults: 64 low / 64 high.
      want_flag = 1'b1;
      idle_n(270);

      // Reload mid-period, takes effect at the 127->0 wrap.
      wait_pos(10, 300);
      tick(1'b1, 10, 3);
      idle_n(150);

      // Invalid configurations are rejected.
      tick(1'b1, 5, 5);
      idle_n(4);
      tick(1'b1, 1, 0);
      idle_n(4);
      tick(1'b1, 0, 0);
      tick(1'b1, 65535, 65535);
      idle_n(25);

      // Stop during a high phase, then restart.
      tick(1'b1, 8, 2);
      idle_n(20);
      wait_pos(5, 40);
      want_flag = 1'b0;
      tick(1'b0, 0, 0);
      idle_n(4);
      want_flag = 1'b1;
      idle_n(20);

      // Two writes before a wrap: last write wins, one ack.
      wait_pos(1, 40);
      tick(1'b1, 6, 3);
      tick(1'b1, 4, 1);
      idle_n(30);

      // Write on the apply edge in IDLE keeps the new value pending.
      want_flag = 1'b0;
      idle_n(3);
      tick(1'b1, 3, 1);
      tick(1'b1, 7, 6);
      idle_n(3);
      want_flag = 1'b1;
      idle_n(20);

      // Stop with a pending write: applied from IDLE.
      wait_pos(2, 40);
      tick(1'b1, 5, 2);
      want_flag = 1'b0;
      idle_n(4);
      want_flag = 1'b1;
      idle_n(20);

      // Reset mid-run with a pending write.
      wait_pos(3, 40);
      tick(1'b1, 9, 4);
      want_rst_n = 1'b0;
      tick(1'b0, 0, 0);
      want_rst_n = 1'b1;
      idle_n(270);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) want_flag = ~want_flag;
         want_rst_n = ($urandom_range(0, 499) != 0);
         tick(($urandom_range(0, 5) == 0), int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
      end
      want_rst_n = 1'b1;
      idle_n(5);

      @(posedge clk);
      #3;
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain got=%0d required=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
